// File: rtl/cdb_rr_arbiter_pkg.sv
// Shared system definitions for the CDB arbiter slice: FU completion packets,
// the ack bundle returned to the FUs, and the broadcast packet on the CDB.
package cdb_rr_arbiter_pkg;

    localparam int NUM_FU    = 4;
    localparam int XLEN      = 32;
    localparam int ROB_TAG_W = 5;

    typedef logic [ROB_TAG_W-1:0] ROB_TAG;

    // One FU's completion: done stays high with tag/value stable until acked
    typedef struct packed {
        logic             done;
        ROB_TAG           rob_tag;
        logic [XLEN-1:0]  v;
    } FU_OUT_PACKET;

    typedef struct packed {
        FU_OUT_PACKET [NUM_FU-1:0] fu_out_packets;
    } EX_CDB_PACKET;

    typedef struct packed {
        logic [NUM_FU-1:0] ack;
    } CDB_EX_PACKET;

    typedef struct packed {
        logic             valid;
        ROB_TAG           rob_tag;
        logic [XLEN-1:0]  v;
    } CDB_PACKET;

    // Pointer width that stays at least one bit even for a single requester
    function automatic int ptrWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_rr_arbiter_rr_pick.sv
// Combinational rotating-priority picker. The request vector is doubled so a
// single linear scan starting at the pointer naturally wraps past the top index.
module cdb_rr_arbiter_rr_pick #(
    parameter int N_FU  = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_FU-1:0]  i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N_FU-1:0]  o_gnt,
    output logic [PTR_W-1:0] o_win,
    output logic             o_any
);

    logic [2*N_FU-1:0] w_reqDouble;
    logic              w_found;

    // First set bit at or above the pointer in the doubled vector is the winner
    always_comb begin
        w_reqDouble = {i_req, i_req};
        w_found     = 1'b0;
        o_win       = '0;
        o_gnt       = '0;
        for (int k = 0; k < 2 * N_FU; k++) begin
            if (!w_found && (k >= int'(i_ptr)) && w_reqDouble[k]) begin
                w_found = 1'b1;
                o_win   = PTR_W'(k % N_FU);
            end
        end
        o_any = w_found;
        if (w_found) begin
            o_gnt[o_win] = 1'b1;
        end
    end

endmodule

// File: rtl/cdb_rr_arbiter.sv
// Round-robin CDB arbiter: acks one completing FU per cycle and broadcasts its
// tag and value in the same cycle. Keeps the rotating pointer plus per-FU wait
// counters and a total broadcast counter for debug visibility.
module cdb_rr_arbiter
    import cdb_rr_arbiter_pkg::*;
#(
    parameter int N_FU   = NUM_FU,
    parameter int WAIT_W = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  EX_CDB_PACKET                 ex_cdb_packet,
    output CDB_EX_PACKET                 cdb_ex_packet,
    output CDB_PACKET                    cdb_packet,
    output logic [N_FU-1:0][WAIT_W-1:0]  wait_cnt,
    output logic [31:0]                  grant_cnt
);

    localparam int                PTR_W    = ptrWidth(N_FU);
    localparam logic [PTR_W-1:0]  LAST_IDX = PTR_W'(N_FU - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

    logic [PTR_W-1:0]             r_ptr;
    logic [N_FU-1:0][WAIT_W-1:0]  r_waitCnt;
    logic [31:0]                  r_grantCnt;

    logic [N_FU-1:0]              w_req;
    logic [N_FU-1:0]              w_gnt;
    logic [PTR_W-1:0]             w_win;
    logic                         w_any;

    // Request vector; held at zero during reset so nothing is acked or broadcast
    always_comb begin
        w_req = '0;
        for (int i = 0; i < N_FU; i++) begin
            w_req[i] = ex_cdb_packet.fu_out_packets[i].done & ~reset;
        end
    end

    cdb_rr_arbiter_rr_pick #(
        .N_FU  (N_FU),
        .PTR_W (PTR_W)
    ) u_pick (
        .i_req (w_req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_win (w_win),
        .o_any (w_any)
    );

    // Ack the winner and mux its tag/value onto the bus; all zero with no winner
    always_comb begin
        cdb_ex_packet     = '0;
        cdb_ex_packet.ack = w_gnt;
        cdb_packet        = '0;
        for (int i = 0; i < N_FU; i++) begin
            if (w_gnt[i]) begin
                cdb_packet.rob_tag = ex_cdb_packet.fu_out_packets[i].rob_tag;
                cdb_packet.v       = ex_cdb_packet.fu_out_packets[i].v;
            end
        end
        cdb_packet.valid = w_any;
    end

    // Rotate priority past the winner and count broadcasts
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr      <= '0;
            r_grantCnt <= '0;
        end else if (w_any) begin
            r_ptr      <= (w_win == LAST_IDX) ? '0 : w_win + PTR_W'(1);
            r_grantCnt <= r_grantCnt + 32'd1;
        end
    end

    // Per-FU stall counters: grow while requesting without ack, clear otherwise
    always_ff @(posedge clock) begin
        if (reset) begin
            r_waitCnt <= '0;
        end else begin
            for (int i = 0; i < N_FU; i++) begin
                if (w_req[i] & ~w_gnt[i]) begin
                    if (r_waitCnt[i] != WAIT_MAX) begin
                        r_waitCnt[i] <= r_waitCnt[i] + WAIT_W'(1);
                    end
                end else begin
                    r_waitCnt[i] <= '0;
                end
            end
        end
    end

    assign wait_cnt  = r_waitCnt;
    assign grant_cnt = r_grantCnt;

endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// Self-checking bench for the round-robin CDB arbiter. A behavioural model
// (integer pointer, per-FU wait counts, broadcast total) predicts every output.
module tb_cdb_rr_arbiter;
    import cdb_rr_arbiter_pkg::*;

    localparam int N        = NUM_FU;
    localparam int WAIT_W   = 4;
    localparam int WAIT_SAT = (1 << WAIT_W) - 1;

    logic                        clock = 1'b0;
    logic                        reset;
    EX_CDB_PACKET                exCdbPacket;
    CDB_EX_PACKET                cdbExPacket;
    CDB_PACKET                   cdbPacket;
    logic [N-1:0][WAIT_W-1:0]    waitCnt;
    logic [31:0]                 grantCnt;

    int          compareCount  = 0;
    int          mismatchCount = 0;

    int          mPtr;
    int          mWait [N];
    logic [31:0] mGrant;
    int          lastWin;

    logic [N-1:0]             obsAck;
    CDB_PACKET                obsCdb;
    logic [N-1:0][WAIT_W-1:0] obsWait;
    logic [31:0]              obsGrant;

    logic [XLEN-1:0] expProd [N];
    ROB_TAG          expTag  [N];

    cdb_rr_arbiter #(
        .N_FU   (N),
        .WAIT_W (WAIT_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .ex_cdb_packet (exCdbPacket),
        .cdb_ex_packet (cdbExPacket),
        .cdb_packet    (cdbPacket),
        .wait_cnt      (waitCnt),
        .grant_cnt     (grantCnt)
    );

    // Free-running clock
    always #5 clock = ~clock;

    task automatic checkVal(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            mismatchCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int fu, input logic done, input ROB_TAG tag, input logic [XLEN-1:0] val);
        exCdbPacket.fu_out_packets[fu].done    = done;
        exCdbPacket.fu_out_packets[fu].rob_tag = tag;
        exCdbPacket.fu_out_packets[fu].v       = val;
    endtask

    // Rotating-priority rule: scan ptr, ptr+1, ... modulo N for the first requester
    function automatic int modelWinner();
        int idx;
        if (reset) return -1;
        for (int off = 0; off < N; off++) begin
            idx = (mPtr + off) % N;
            if (exCdbPacket.fu_out_packets[idx].done) return idx;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string tag);
        int           w;
        logic [N-1:0] expAck;
        CDB_PACKET    expCdb;
        w      = modelWinner();
        expAck = '0;
        expCdb = '0;
        if (w >= 0) begin
            expAck[w]      = 1'b1;
            expCdb.valid   = 1'b1;
            expCdb.rob_tag = exCdbPacket.fu_out_packets[w].rob_tag;
            expCdb.v       = exCdbPacket.fu_out_packets[w].v;
        end
        obsAck   = cdbExPacket.ack;
        obsCdb   = cdbPacket;
        obsWait  = waitCnt;
        obsGrant = grantCnt;
        checkVal({tag, "_ack"}, 64'(obsAck), 64'(expAck));
        checkVal({tag, "_cdb"}, 64'(obsCdb), 64'(expCdb));
        for (int i = 0; i < N; i++) begin
            checkVal($sformatf("%s_wait%0d", tag, i), 64'(obsWait[i]), 64'(mWait[i]));
        end
        checkVal({tag, "_grant_cnt"}, 64'(obsGrant), 64'(mGrant));
    endtask

    task automatic modelAdvance();
        int w;
        w = modelWinner();
        if (reset) begin
            mPtr    = 0;
            mGrant  = '0;
            lastWin = -1;
            for (int i = 0; i < N; i++) mWait[i] = 0;
            return;
        end
        for (int i = 0; i < N; i++) begin
            if (exCdbPacket.fu_out_packets[i].done && i != w)
                mWait[i] = (mWait[i] >= WAIT_SAT) ? WAIT_SAT : mWait[i] + 1;
            else
                mWait[i] = 0;
        end
        if (w >= 0) begin
            mPtr   = (w + 1) % N;
            mGrant = mGrant + 32'd1;
        end
        lastWin = w;
    endtask

    // One cycle: check mid-cycle, advance model at posedge, acked FU drops done
    task automatic stepCycle(input string tag);
        @(negedge clock);
        checkOutput(tag);
        @(posedge clock);
        modelAdvance();
        #1;
        if (lastWin >= 0) exCdbPacket.fu_out_packets[lastWin].done = 1'b0;
    endtask

    initial begin
        CDB_PACKET   refCdb;
        logic [31:0] grantBefore;
        logic [XLEN-1:0] a, b;
        int          opsDone;
        int          cycles;

        reset       = 1'b1;
        exCdbPacket = '0;
        mPtr        = 0;
        mGrant      = '0;
        lastWin     = -1;
        for (int i = 0; i < N; i++) mWait[i] = 0;

        // Reset for two cycles
        stepCycle("reset0");
        stepCycle("reset1");
        reset = 1'b0;

        // Single request from FU1
        applyStimulus(1, 1'b1, ROB_TAG'(2), 32'd6);
        stepCycle("single");
        refCdb = '0; refCdb.valid = 1'b1; refCdb.rob_tag = ROB_TAG'(2); refCdb.v = 32'd6;
        checkVal("single_ack_const", 64'(obsAck), 64'(4'b0010));
        checkVal("single_cdb_const", 64'(obsCdb), 64'(refCdb));
        stepCycle("after_single");
        checkVal("single_grant_cnt_const", 64'(obsGrant), 64'd1);

        // ptr is 2: FU3 alone brings it back to 0
        applyStimulus(3, 1'b1, ROB_TAG'(7), 32'h33);
        stepCycle("to_ptr0");

        // All four request together and hold until acked
        for (int i = 0; i < N; i++) applyStimulus(i, 1'b1, ROB_TAG'(i + 8), $urandom);
        for (int s = 0; s < N; s++) begin
            stepCycle("allreq");
            checkVal($sformatf("allreq_order%0d", s), 64'(obsAck), 64'(1 << s));
            if (s == N - 1) checkVal("allreq_wait3_peak", 64'(obsWait[3]), 64'd3);
        end
        stepCycle("allreq_idle");
        checkVal("allreq_wait3_clear", 64'(obsWait[3]), 64'd0);

        // ptr wrapped to 0: FU1 beats FU3, then FU3
        applyStimulus(1, 1'b1, ROB_TAG'(1), 32'h11);
        applyStimulus(3, 1'b1, ROB_TAG'(3), 32'h13);
        stepCycle("wrap_a");
        checkVal("wrap_first_fu1", 64'(obsAck), 64'(4'b0010));
        stepCycle("wrap_b");
        checkVal("wrap_then_fu3", 64'(obsAck), 64'(4'b1000));

        // FU1 alone sets ptr to 2, then FUs 0 and 1 request: FU0 first, then FU1
        applyStimulus(1, 1'b1, ROB_TAG'(4), 32'h44);
        stepCycle("skip_setup");
        applyStimulus(0, 1'b1, ROB_TAG'(20), $urandom);
        applyStimulus(1, 1'b1, ROB_TAG'(21), $urandom);
        stepCycle("skip_a");
        checkVal("skip_first_fu0", 64'(obsAck), 64'(4'b0001));
        stepCycle("skip_b");
        checkVal("skip_then_fu1", 64'(obsAck), 64'(4'b0010));
        // ptr should now be 2: FU2 beats FU1
        applyStimulus(1, 1'b1, ROB_TAG'(22), $urandom);
        applyStimulus(2, 1'b1, ROB_TAG'(23), $urandom);
        stepCycle("skip_c");
        checkVal("skip_ptr2_fu2", 64'(obsAck), 64'(4'b0100));
        stepCycle("skip_d");

        // Idle for five cycles
        grantBefore = mGrant;
        for (int c = 0; c < 5; c++) begin
            stepCycle("idle");
            checkVal("idle_ack_zero", 64'(obsAck), 64'd0);
            checkVal("idle_valid_zero", 64'(obsCdb.valid), 64'd0);
        end
        checkVal("idle_grant_unchanged", 64'(obsGrant), 64'(grantBefore));

        // Reset asserted while FU2 requests
        applyStimulus(2, 1'b1, ROB_TAG'(9), 32'h99);
        reset = 1'b1;
        stepCycle("rst_mid");
        checkVal("rst_mid_ack_zero", 64'(obsAck), 64'd0);
        checkVal("rst_mid_cdb_zero", 64'(obsCdb), 64'd0);
        reset = 1'b0;
        stepCycle("rst_release");
        checkVal("rst_release_fu2", 64'(obsAck), 64'(4'b0100));
        checkVal("rst_release_wait2", 64'(obsWait[2]), 64'd0);

        // Multiplier-style completions: random operands, contention on all FUs
        opsDone = 0;
        cycles  = 0;
        while (opsDone < 31 && cycles < 2000) begin
            for (int i = 0; i < N; i++) begin
                if (!exCdbPacket.fu_out_packets[i].done && $urandom_range(0, 1) == 1) begin
                    a          = $urandom;
                    b          = $urandom;
                    expProd[i] = a * b;
                    expTag[i]  = ROB_TAG'($urandom);
                    applyStimulus(i, 1'b1, expTag[i], expProd[i]);
                end
            end
            stepCycle("rand");
            if (lastWin >= 0) begin
                checkVal("mult_v", 64'(obsCdb.v), 64'(expProd[lastWin]));
                checkVal("mult_tag", 64'(obsCdb.rob_tag), 64'(expTag[lastWin]));
                opsDone++;
            end
            cycles++;
        end
        checkVal("mult_ops_completed", 64'(opsDone >= 31), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
